// File: rtl/pwmcap_pkg.sv
// Shared types and default constants for the PWM capture block.
package pwmcap_pkg;

    localparam int unsigned DEF_DIV = 10;
    localparam int unsigned DEF_NOM = 65536;
    localparam int unsigned DEF_TOL = 4;

    typedef enum logic [1:0] {
        SYNC,
        HIGH,
        LOW
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin followed by a registered
// rise/fall detector; an edge on the pin shows up as an event 3 clk later.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        s1_d   = pin;
        s2_d   = s1_q;
        prev_d = s2_q;
        rise_d = s2_q & ~prev_q;
        fall_d = ~s2_q & prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input in sample ticks, flags
// out-of-tolerance periods and a pin that stops toggling.
module pwm_capture
    import pwmcap_pkg::*;
#(
    parameter int unsigned DIV   = DEF_DIV,
    parameter int unsigned CNT_W = 17,
    parameter int unsigned NOM   = DEF_NOM,
    parameter int unsigned TOL   = DEF_TOL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [15:0]      duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             period_err,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LIM  = CNT_W'(NOM + TOL);
    localparam logic [CNT_W-1:0] LO_B = CNT_W'((NOM > TOL) ? (NOM - TOL) : 0);

    logic rise, fall, tick;

    sync_edge u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .pin  (pwm_in),
        .rise (rise),
        .fall (fall)
    );

    logic [DW-1:0]    div_q, div_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_tk, per_tk;
    logic [15:0]      duty_q, duty_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d, err_q, err_d;
    logic             shi_q, shi_d, slo_q, slo_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign tick  = (div_q == DW'(DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    // The tick of the current clk is folded in before any edge is acted on,
    // so a coincident tick belongs to the phase being left.
    assign hi_tk  = tick ? sat_inc(hi_cnt_q) : hi_cnt_q;
    assign per_tk = tick ? sat_inc(per_cnt_q) : per_cnt_q;

    always_comb begin
        state_d   = state_q;
        hi_cnt_d  = hi_cnt_q;
        per_cnt_d = per_cnt_q;
        duty_d    = duty_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        shi_d     = shi_q;
        slo_d     = slo_q;
        case (state_q)
            SYNC: begin
                if (rise) begin
                    state_d   = HIGH;
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                end
            end
            HIGH: begin
                hi_cnt_d  = hi_tk;
                per_cnt_d = per_tk;
                if (per_tk >= LIM) begin
                    state_d   = SYNC;
                    shi_d     = 1'b1;
                    slo_d     = 1'b0;
                    duty_d    = '1;
                    valid_d   = 1'b1;
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                end else if (fall) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                per_cnt_d = per_tk;
                if (per_tk >= LIM) begin
                    state_d   = SYNC;
                    shi_d     = 1'b0;
                    slo_d     = 1'b1;
                    duty_d    = '0;
                    valid_d   = 1'b1;
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                end else if (rise) begin
                    state_d   = HIGH;
                    duty_d    = (|hi_cnt_q[CNT_W-1:16]) ? 16'hFFFF : hi_cnt_q[15:0];
                    period_d  = per_tk;
                    err_d     = (per_tk > LIM) || (per_tk < LO_B);
                    shi_d     = 1'b0;
                    slo_d     = 1'b0;
                    valid_d   = 1'b1;
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            state_q   <= SYNC;
            hi_cnt_q  <= '0;
            per_cnt_q <= '0;
            duty_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            shi_q     <= 1'b0;
            slo_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            state_q   <= state_d;
            hi_cnt_q  <= hi_cnt_d;
            per_cnt_q <= per_cnt_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            shi_q     <= shi_d;
            slo_q     <= slo_d;
        end
    end

    assign duty       = duty_q;
    assign period     = period_q;
    assign valid      = valid_q;
    assign period_err = err_q;
    assign stuck_hi   = shi_q;
    assign stuck_lo   = slo_q;

endmodule
